// File: rtl/axi_burst_mem_slave.sv
// AXI4 memory-backed slave: FIXED/INCR/WRAP bursts up to 256 beats into a word array.
// Write and read channels run independent FSMs; a read in the same cycle as a write sees old data.
module axi_burst_mem_slave #(
  parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 10
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]                      AWLEN,
  input  logic [1:0]                      AWBURST,
  input  logic                            AWVALID,
  output logic                            AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                            WLAST,
  input  logic                            WVALID,
  output logic                            WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     BID,
  output logic [1:0]                      BRESP,
  output logic                            BVALID,
  input  logic                            BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]                      ARLEN,
  input  logic [1:0]                      ARBURST,
  input  logic                            ARVALID,
  output logic                            ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                      RRESP,
  output logic                            RLAST,
  output logic                            RVALID,
  input  logic                            RREADY
);

  localparam int unsigned IW    = C_S_AXI_ID_WIDTH;
  localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW    = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned SW    = DW / 8;
  localparam int unsigned DEPTH = 1 << (AW - 2);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

  // Next beat address; WRAP with an unsupported length behaves as INCR.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr,
                                               input logic [7:0]    len,
                                               input logic [1:0]    burst);
    logic [AW-1:0] mask;
    logic [AW-1:0] incr;
    logic [AW-1:0] res;
    mask = AW'((32'(len) + 32'd1) * 32'd4 - 32'd1);
    incr = addr + AW'(4);
    if (burst == BURST_FIXED) begin
      res = addr;
    end else if (burst == BURST_WRAP &&
                 (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
      res = (addr & ~mask) | (incr & mask);
    end else begin
      res = incr;
    end
    return res;
  endfunction

  logic [DW-1:0] mem [DEPTH];

  w_state_e      w_state_q, w_state_d;
  logic          awready_q, awready_d;
  logic          wready_q,  wready_d;
  logic          bvalid_q,  bvalid_d;
  logic [IW-1:0] bid_q,     bid_d;
  logic [1:0]    bresp_q,   bresp_d;
  logic [IW-1:0] wid_q,     wid_d;
  logic [AW-1:0] waddr_q,   waddr_d;
  logic [7:0]    wlen_q,    wlen_d;
  logic [1:0]    wburst_q,  wburst_d;
  logic [7:0]    wbeat_q,   wbeat_d;
  logic          werr_q,    werr_d;
  logic          w_last_c;
  logic          mem_we_c;

  r_state_e      r_state_q, r_state_d;
  logic          arready_q, arready_d;
  logic          rvalid_q,  rvalid_d;
  logic          rlast_q,   rlast_d;
  logic [IW-1:0] rid_q,     rid_d;
  logic [DW-1:0] rdata_q,   rdata_d;
  logic [AW-1:0] raddr_q,   raddr_d;
  logic [7:0]    rlen_q,    rlen_d;
  logic [1:0]    rburst_q,  rburst_d;
  logic [7:0]    rbeat_q,   rbeat_d;
  logic [AW-1:0] r_next_c;

  // Write channel: address, data beats, then response.
  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    wid_d     = wid_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wburst_d  = wburst_q;
    wbeat_d   = wbeat_q;
    werr_d    = werr_q;
    w_last_c  = (wbeat_q == wlen_q);
    mem_we_c  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (AWVALID && awready_q) begin
          awready_d = 1'b0;
          wready_d  = 1'b1;
          wid_d     = AWID;
          waddr_d   = AWADDR & ~AW'(3);
          wlen_d    = AWLEN;
          wburst_d  = AWBURST;
          wbeat_d   = 8'd0;
          werr_d    = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (WVALID && wready_q) begin
          mem_we_c = 1'b1;
          werr_d   = werr_q | (WLAST != w_last_c);
          waddr_d  = next_addr(waddr_q, wlen_q, wburst_q);
          wbeat_d  = wbeat_q + 8'd1;
          if (w_last_c) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bid_d     = wid_q;
            bresp_d   = werr_d ? RESP_SLVERR : RESP_OKAY;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (BREADY && bvalid_q) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read channel: one fetch cycle after AR, then back-to-back beats while RREADY holds.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rburst_d  = rburst_q;
    rbeat_d   = rbeat_q;
    r_next_c  = next_addr(raddr_q, rlen_q, rburst_q);
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ARVALID && arready_q) begin
          arready_d = 1'b0;
          rid_d     = ARID;
          raddr_d   = ARADDR & ~AW'(3);
          rlen_d    = ARLEN;
          rburst_d  = ARBURST;
          rbeat_d   = 8'd0;
          r_state_d = R_FETCH;
        end
      end
      R_FETCH: begin
        rdata_d   = mem[raddr_q[AW-1:2]];
        rvalid_d  = 1'b1;
        rlast_d   = (rlen_q == 8'd0);
        r_state_d = R_DATA;
      end
      R_DATA: begin
        if (rvalid_q && RREADY) begin
          if (rbeat_q == rlen_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            raddr_d = r_next_c;
            rbeat_d = rbeat_q + 8'd1;
            rdata_d = mem[r_next_c[AW-1:2]];
            rlast_d = ((rbeat_q + 8'd1) == rlen_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
      wid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= 8'd0;
      wburst_q  <= 2'b00;
      wbeat_q   <= 8'd0;
      werr_q    <= 1'b0;
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      raddr_q   <= '0;
      rlen_q    <= 8'd0;
      rburst_q  <= 2'b00;
      rbeat_q   <= 8'd0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      wid_q     <= wid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wburst_q  <= wburst_d;
      wbeat_q   <= wbeat_d;
      werr_q    <= werr_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rburst_q  <= rburst_d;
      rbeat_q   <= rbeat_d;
    end
  end

  // Storage is deliberately outside reset so contents survive ARESET.
  always_ff @(posedge ACLK) begin
    if (mem_we_c) begin
      for (int b = 0; b < int'(SW); b++) begin
        if (WSTRB[b]) mem[waddr_q[AW-1:2]][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BID     = bid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RLAST   = rlast_q;
  assign RID     = rid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = RESP_OKAY;

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Directed bench for axi_burst_mem_slave: burst types, strobes, back-pressure, errors, concurrency, reset.
module tb_axi_burst_mem_slave;

  localparam int unsigned IW = 2;
  localparam int unsigned AW = 10;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic [IW-1:0] AWID;
  logic [AW-1:0] AWADDR;
  logic [7:0]    AWLEN;
  logic [1:0]    AWBURST;
  logic          AWVALID;
  logic          AWREADY;
  logic [31:0]   WDATA;
  logic [3:0]    WSTRB;
  logic          WLAST;
  logic          WVALID;
  logic          WREADY;
  logic [IW-1:0] BID;
  logic [1:0]    BRESP;
  logic          BVALID;
  logic          BREADY;
  logic [IW-1:0] ARID;
  logic [AW-1:0] ARADDR;
  logic [7:0]    ARLEN;
  logic [1:0]    ARBURST;
  logic          ARVALID;
  logic          ARREADY;
  logic [IW-1:0] RID;
  logic [31:0]   RDATA;
  logic [1:0]    RRESP;
  logic          RLAST;
  logic          RVALID;
  logic          RREADY;

  axi_burst_mem_slave #(
    .C_S_AXI_ID_WIDTH  (IW),
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(AW)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] wdat [16];
  logic [31:0] rexp [16];
  logic [1:0]  bresp_v;
  logic [IW-1:0] bid_v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic axi_write(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [3:0] strb, input int wlast_at,
                           input int bready_delay, output logic [1:0] bresp, output logic [IW-1:0] bid);
    int n;
    AWID = id; AWADDR = addr; AWLEN = len; AWBURST = burst; AWVALID = 1'b1;
    n = 0;
    while (AWREADY !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) chk("aw_timeout", 32'(n), 32'd0);
    tick();
    AWVALID = 1'b0;
    chk("aw_drop", 32'(AWREADY), 32'd0);
    for (int i = 0; i <= int'(len); i++) begin
      WDATA  = wdat[i];
      WSTRB  = strb;
      WLAST  = (wlast_at < 0) ? (i == int'(len)) : (i == wlast_at);
      WVALID = 1'b1;
      n = 0;
      while (WREADY !== 1'b1 && n < 50) begin tick(); n++; end
      if (n >= 50) chk("w_timeout", 32'(n), 32'd0);
      tick();
    end
    WVALID = 1'b0;
    WLAST  = 1'b0;
    n = 0;
    while (BVALID !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) chk("b_timeout", 32'(n), 32'd0);
    for (int d = 0; d < bready_delay; d++) begin
      tick();
      chk("b_hold_bvalid", 32'(BVALID), 32'd1);
      chk("b_hold_awready", 32'(AWREADY), 32'd0);
    end
    bresp  = BRESP;
    bid    = BID;
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    chk("b_done_bvalid", 32'(BVALID), 32'd0);
    chk("b_done_awready", 32'(AWREADY), 32'd1);
  endtask

  task automatic axi_read(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input bit stall);
    int n;
    ARID = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARVALID = 1'b1;
    n = 0;
    while (ARREADY !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) chk("ar_timeout", 32'(n), 32'd0);
    tick();
    ARVALID = 1'b0;
    chk("ar_latency_rvalid", 32'(RVALID), 32'd0);
    chk("ar_drop", 32'(ARREADY), 32'd0);
    tick();
    RREADY = !stall;
    for (int i = 0; i <= int'(len); i++) begin
      chk("r_valid", 32'(RVALID), 32'd1);
      chk("r_data", RDATA, rexp[i]);
      chk("r_last", 32'(RLAST), 32'(i == int'(len)));
      chk("r_id", 32'(RID), 32'(id));
      chk("r_resp", 32'(RRESP), 32'd0);
      if (stall) begin
        RREADY = 1'b0;
        tick();
        chk("r_stall_valid", 32'(RVALID), 32'd1);
        chk("r_stall_data", RDATA, rexp[i]);
        chk("r_stall_last", 32'(RLAST), 32'(i == int'(len)));
        RREADY = 1'b1;
      end
      tick();
    end
    RREADY = 1'b0;
    chk("r_end_rvalid", 32'(RVALID), 32'd0);
    chk("r_end_arready", 32'(ARREADY), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET = 1'b1;
    AWID = '0; AWADDR = '0; AWLEN = 8'd0; AWBURST = 2'b01; AWVALID = 1'b0;
    WDATA = 32'd0; WSTRB = 4'h0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = 8'd0; ARBURST = 2'b01; ARVALID = 1'b0; RREADY = 1'b0;

    // Reset values
    #12;
    chk("rst_awready", 32'(AWREADY), 32'd0);
    chk("rst_wready", 32'(WREADY), 32'd0);
    chk("rst_bvalid", 32'(BVALID), 32'd0);
    chk("rst_arready", 32'(ARREADY), 32'd0);
    chk("rst_rvalid", 32'(RVALID), 32'd0);
    chk("rst_rlast", 32'(RLAST), 32'd0);
    chk("rst_bid", 32'(BID), 32'd0);
    chk("rst_rid", 32'(RID), 32'd0);
    chk("rst_bresp", 32'(BRESP), 32'd0);
    chk("rst_rresp", 32'(RRESP), 32'd0);
    chk("rst_rdata", RDATA, 32'd0);
    ARESET = 1'b0;
    #1;
    chk("rel_arready_pre", 32'(ARREADY), 32'd0);
    tick();
    chk("rel_arready", 32'(ARREADY), 32'd1);
    chk("rel_awready", 32'(AWREADY), 32'd1);

    // 1: INCR write then INCR readback
    for (int i = 0; i < 15; i++) wdat[i] = 32'hFFFF_FFFF - 32'(i) * 32'h1111_1111;
    wdat[15] = 32'h00ab_cdef;
    axi_write(2'd1, 10'h000, 8'd15, 2'b01, 4'hF, -1, 0, bresp_v, bid_v);
    chk("t1_bresp", 32'(bresp_v), 32'd0);
    chk("t1_bid", 32'(bid_v), 32'd1);
    for (int i = 0; i < 16; i++) rexp[i] = wdat[i];
    chk("t1_table_last", rexp[14], 32'h1111_1111);
    axi_read(2'd2, 10'h000, 8'd15, 2'b01, 1'b0);

    // 2: WRAP reads over mem[i]=i
    for (int i = 0; i < 16; i++) wdat[i] = 32'(i);
    axi_write(2'd0, 10'h000, 8'd15, 2'b01, 4'hF, -1, 0, bresp_v, bid_v);
    chk("t2_bresp", 32'(bresp_v), 32'd0);
    for (int i = 0; i < 16; i++) rexp[i] = 32'((i + 2) % 16);
    axi_read(2'd1, 10'h008, 8'd15, 2'b10, 1'b0);
    rexp[0] = 32'd3; rexp[1] = 32'd0; rexp[2] = 32'd1; rexp[3] = 32'd2;
    axi_read(2'd3, 10'h00E, 8'd3, 2'b10, 1'b0);
    rexp[0] = 32'd12; rexp[1] = 32'd13; rexp[2] = 32'd14;
    axi_read(2'd0, 10'h030, 8'd2, 2'b10, 1'b0);

    // 3: byte strobes and FIXED burst
    wdat[0] = 32'hAAAA_AAAA;
    axi_write(2'd0, 10'h010, 8'd0, 2'b01, 4'hF, -1, 0, bresp_v, bid_v);
    wdat[0] = 32'h1122_3344;
    axi_write(2'd0, 10'h010, 8'd0, 2'b01, 4'b0101, -1, 0, bresp_v, bid_v);
    rexp[0] = 32'hAA22_AA44;
    axi_read(2'd0, 10'h010, 8'd0, 2'b01, 1'b0);
    wdat[0] = 32'd1; wdat[1] = 32'd2; wdat[2] = 32'd3; wdat[3] = 32'd4;
    axi_write(2'd0, 10'h020, 8'd3, 2'b00, 4'hF, -1, 0, bresp_v, bid_v);
    chk("t3_fixed_bresp", 32'(bresp_v), 32'd0);
    rexp[0] = 32'd4; rexp[1] = 32'd9;
    axi_read(2'd0, 10'h020, 8'd1, 2'b01, 1'b0);

    // 4: RREADY toggling, then BREADY held off
    rexp[0] = 32'd0; rexp[1] = 32'd1; rexp[2] = 32'd2; rexp[3] = 32'd3;
    rexp[4] = 32'hAA22_AA44; rexp[5] = 32'd5; rexp[6] = 32'd6; rexp[7] = 32'd7;
    axi_read(2'd1, 10'h000, 8'd7, 2'b01, 1'b1);
    wdat[0] = 32'hCAFE_F00D;
    axi_write(2'd3, 10'h080, 8'd0, 2'b01, 4'hF, -1, 5, bresp_v, bid_v);
    chk("t4_bresp", 32'(bresp_v), 32'd0);
    chk("t4_bid", 32'(bid_v), 32'd3);
    rexp[0] = 32'hCAFE_F00D;
    axi_read(2'd0, 10'h080, 8'd0, 2'b01, 1'b0);

    // 5: early WLAST yields SLVERR; concurrent disjoint write and read
    for (int i = 0; i < 4; i++) wdat[i] = 32'h10 + 32'(i);
    axi_write(2'd2, 10'h100, 8'd3, 2'b01, 4'hF, 2, 0, bresp_v, bid_v);
    chk("t5_err_bresp", 32'(bresp_v), 32'd2);
    chk("t5_err_bid", 32'(bid_v), 32'd2);
    for (int i = 0; i < 16; i++) wdat[i] = 32'hA000_0000 + 32'(i);
    for (int i = 0; i < 16; i++) rexp[i] = 32'(i);
    rexp[4] = 32'hAA22_AA44;
    rexp[8] = 32'd4;
    fork
      axi_write(2'd1, 10'h200, 8'd15, 2'b01, 4'hF, -1, 0, bresp_v, bid_v);
      axi_read(2'd2, 10'h000, 8'd15, 2'b01, 1'b0);
    join
    chk("t5_conc_bresp", 32'(bresp_v), 32'd0);
    for (int i = 0; i < 16; i++) rexp[i] = 32'hA000_0000 + 32'(i);
    axi_read(2'd1, 10'h200, 8'd15, 2'b01, 1'b0);

    // 6: reset during beat 5 of a read
    ARID = 2'd3; ARADDR = 10'h200; ARLEN = 8'd15; ARBURST = 2'b01; ARVALID = 1'b1;
    begin
      int n;
      n = 0;
      while (ARREADY !== 1'b1 && n < 50) begin tick(); n++; end
      if (n >= 50) chk("t6_ar_timeout", 32'(n), 32'd0);
    end
    tick();
    ARVALID = 1'b0;
    tick();
    RREADY = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("t6_beat5_data", RDATA, 32'hA000_0004);
    chk("t6_beat5_valid", 32'(RVALID), 32'd1);
    #2;
    ARESET = 1'b1;
    #1;
    RREADY = 1'b0;
    chk("t6_rst_rvalid", 32'(RVALID), 32'd0);
    chk("t6_rst_rdata", RDATA, 32'd0);
    chk("t6_rst_rid", 32'(RID), 32'd0);
    chk("t6_rst_arready", 32'(ARREADY), 32'd0);
    @(posedge ACLK);
    #2;
    ARESET = 1'b0;
    #1;
    chk("t6_rel_arready_pre", 32'(ARREADY), 32'd0);
    tick();
    chk("t6_rel_arready", 32'(ARREADY), 32'd1);
    chk("t6_rel_rvalid", 32'(RVALID), 32'd0);
    axi_read(2'd0, 10'h200, 8'd15, 2'b01, 1'b0);
    rexp[0] = 32'hCAFE_F00D;
    axi_read(2'd0, 10'h080, 8'd0, 2'b01, 1'b0);

    // INCR wraps modulo the 1 KiB window
    wdat[0] = 32'h0000_1234; wdat[1] = 32'h0000_5678;
    axi_write(2'd0, 10'h3FC, 8'd1, 2'b01, 4'hF, -1, 0, bresp_v, bid_v);
    rexp[0] = 32'h0000_5678;
    axi_read(2'd0, 10'h000, 8'd0, 2'b01, 1'b0);
    rexp[0] = 32'h0000_1234; rexp[1] = 32'h0000_5678; rexp[2] = 32'd1;
    axi_read(2'd0, 10'h3FC, 8'd2, 2'b11, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
